bcd_serial_adder_ctrl: RTL and testbench



---
 rtl/bcd_serial_adder_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_serial_adder_ctrl
//
// Purpose:
//   Multi-digit BCD adder sequencer. Two packed DIGITS-digit BCD operands are
//   added one decimal digit per clock, least significant digit first, through
//   a single shared digit adder with a carry chain held in a register. The
//   upstream controller gets a start/busy/done handshake.
//
// Parameters:
//   DIGITS     number of BCD digits per operand (1..8)
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   start      add request, sampled only while idle
//   a, b       packed BCD operands, digit i at bits [4i+3:4i]
//   busy       high while digits are being added
//   done       one-cycle pulse, result valid
//   sum        packed BCD result, held until the next accepted start
//   carry_out  decimal carry out of the top digit, held with sum
//   err        invalid-digit flag
//
// Optional feature (compile-time macro):
//   BCD_SEQ_INVALID_CHECK_EN  when defined, err is registered at each accepted
//                             start and is high if any digit of a or b exceeds
//                             9. When undefined, err is tied low and no check
//                             logic exists.
// -----------------------------------------------------------------------------
module bcd_serial_adder_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  carry_out,
   output logic                  err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index is wide enough for the largest legal DIGITS (8).
   localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

   state_t                r_state;
   logic [2:0]            r_idx;
   logic                  r_carry;
   logic                  r_carry_out;
   logic [4*DIGITS-1:0]   r_sum;
   logic [4*DIGITS-1:0]   r_a_op;
   logic [4*DIGITS-1:0]   r_b_op;

   logic                  w_accept;
   logic [3:0]            w_a_dig;
   logic [3:0]            w_b_dig;
   logic [4:0]            w_res;

   // One decimal digit add: returns {carry, digit}. Binary sums above 9 are
   // corrected by +6 so the low nibble wraps into the BCD range.
   function automatic logic [4:0] bcd_digit_add(
      input logic [3:0] x,
      input logic [3:0] y,
      input logic       cin
   );
      logic [4:0] s;
      logic [4:0] s_adj;
      s     = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
      s_adj = s + 5'd6;
      if (s > 5'd9)
         return {1'b1, s_adj[3:0]};
      else
         return {1'b0, s[3:0]};
   endfunction

`ifdef BCD_SEQ_INVALID_CHECK_EN
   logic r_err;

   function automatic logic any_invalid_digit(
      input logic [4*DIGITS-1:0] x,
      input logic [4*DIGITS-1:0] y
   );
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9)
            bad = 1'b1;
      end
      return bad;
   endfunction
`endif

   assign w_accept = (r_state == IDLE) && start;

   // Select the operand digits at the current index.
   always_comb begin
      w_a_dig = 4'd0;
      w_b_dig = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == 3'(i)) begin
            w_a_dig = r_a_op[4*i +: 4];
            w_b_dig = r_b_op[4*i +: 4];
         end
      end
   end

   assign w_res = bcd_digit_add(w_a_dig, w_b_dig, r_carry);

   // Operand copies carry no control meaning, so they are loaded without reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a_op <= a;
         r_b_op <= b;
      end
   end

   // Sequencer FSM with result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_idx       <= 3'd0;
         r_carry     <= 1'b0;
         r_carry_out <= 1'b0;
         r_sum       <= '0;
`ifdef BCD_SEQ_INVALID_CHECK_EN
         r_err       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sum       <= '0;
                  r_carry     <= 1'b0;
                  r_carry_out <= 1'b0;
                  r_idx       <= 3'd0;
`ifdef BCD_SEQ_INVALID_CHECK_EN
                  r_err       <= any_invalid_digit(a, b);
`endif
                  r_state     <= ADD;
               end
            end
            ADD: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (r_idx == 3'(i))
                     r_sum[4*i +: 4] <= w_res[3:0];
               end
               r_carry <= w_res[4];
               if (r_idx == LAST_IDX) begin
                  // Final carry is published together with the DONE state.
                  r_carry_out <= w_res[4];
                  r_state     <= DONE;
               end else begin
                  r_idx <= r_idx + 3'd1;
               end
            end
            DONE: begin
               // start is deliberately ignored here; it is not queued.
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Handshake outputs decode straight from the state register, so they are
   // glitch-free and mutually exclusive.
   assign busy      = (r_state == ADD);
   assign done      = (r_state == DONE);
   assign sum       = r_sum;
   assign carry_out = r_carry_out;

`ifdef BCD_SEQ_INVALID_CHECK_EN
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_adder_ctrl
//
// Self-checking bench for bcd_serial_adder_ctrl. A DIGITS=4 instance is driven
// by directed steps with expected results queued at start and compared when
// done pulses; a DIGITS=1 instance covers the single-digit case.
// -----------------------------------------------------------------------------
module tb_bcd_serial_adder_ctrl;

   localparam int D = 4;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [4*D-1:0]  a;
   logic [4*D-1:0]  b;
   logic            busy;
   logic            done;
   logic [4*D-1:0]  sum;
   logic            carry_out;
   logic            err;

   logic            start1;
   logic [3:0]      a1;
   logic [3:0]      b1;
   logic            busy1;
   logic            done1;
   logic [3:0]      sum1;
   logic            carry1;
   logic            err1;

   int n_cmp = 0;
   int n_mis = 0;
   int n_done = 0;

   typedef struct {
      logic [4*D-1:0] sum;
      logic           co;
      logic           chk_sum;
      logic           err;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;

   bcd_serial_adder_ctrl #(.DIGITS(D)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
      .err       (err)
   );

   bcd_serial_adder_ctrl #(.DIGITS(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start1),
      .a         (a1),
      .b         (b1),
      .busy      (busy1),
      .done      (done1),
      .sum       (sum1),
      .carry_out (carry1),
      .err       (err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int bcd2int(input logic [4*D-1:0] x);
      int v;
      v = 0;
      for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
      return v;
   endfunction

   function automatic logic [4*D-1:0] int2bcd(input int v);
      logic [4*D-1:0] r;
      int t;
      t = v;
      r = '0;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic exp_t model(input logic [4*D-1:0] x, input logic [4*D-1:0] y,
                                  input logic chk_sum, input logic err_exp);
      exp_t e;
      int tot;
      tot       = bcd2int(x) + bcd2int(y);
      e.sum     = int2bcd(tot % 10000);
      e.co      = (tot >= 10000);
      e.chk_sum = chk_sum;
      e.err     = err_exp;
      return e;
   endfunction

   // Scoreboard consumer: every done pulse pops one expectation.
   always @(negedge clk) begin
      chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (done) begin
         n_done++;
         chk("sb_nonempty_at_done", {31'd0, q.size() == 0}, 32'd0);
         if (q.size() != 0) begin
            e_mon = q.pop_front();
            if (e_mon.chk_sum) begin
               chk("sum", {16'd0, sum}, {16'd0, e_mon.sum});
               chk("carry_out", {31'd0, carry_out}, {31'd0, e_mon.co});
            end
            chk("err_at_done", {31'd0, err}, {31'd0, e_mon.err});
         end
      end
   end

   // One addition with start for a single cycle; checks latency, busy length,
   // single-cycle done and result hold.
   task automatic do_add(input logic [4*D-1:0] xa, input logic [4*D-1:0] xb,
                         input logic chk_sum, input logic err_exp);
      int lat;
      int nb;
      exp_t e;
      e = model(xa, xb, chk_sum, err_exp);
      @(negedge clk);
      a = xa; b = xb; start = 1'b1;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      lat = 0; nb = 0;
      while (!done && lat < 20) begin
         if (busy) nb++;
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, D);
      chk("busy_cycles", nb, D);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      if (chk_sum) begin
         chk("sum_hold", {16'd0, sum}, {16'd0, e.sum});
         chk("carry_hold", {31'd0, carry_out}, {31'd0, e.co});
      end
   endtask

   initial begin
      int d0;
      int lat1;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      start1 = 1'b0; a1 = '0; b1 = '0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_carry", {31'd0, carry_out}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic additions, carry ripple and a few random valid operands.
      do_add(16'h1234, 16'h5678, 1'b1, 1'b0);
      do_add(16'h9999, 16'h0001, 1'b1, 1'b0);
      do_add(16'h0000, 16'h0000, 1'b1, 1'b0);
      do_add(16'h9999, 16'h9999, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++)
         do_add(int2bcd(int'($urandom_range(0, 9999))),
                int2bcd(int'($urandom_range(0, 9999))), 1'b1, 1'b0);

      // start held high through the whole operation, operands changed.
      d0 = n_done;
      @(negedge clk);
      a = 16'h1234; b = 16'h5678; start = 1'b1;
      q.push_back(model(16'h1234, 16'h5678, 1'b1, 1'b0));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a = 16'h9999; b = 16'h9999;
      end
      chk("held_done_now", {31'd0, done}, 32'd1);
      @(negedge clk);
      start = 1'b0;
      chk("held_no_restart", {31'd0, busy}, 32'd0);
      repeat (6) @(negedge clk);
      chk("held_single_add", n_done - d0, 1);
      do_add(16'h0042, 16'h0058, 1'b1, 1'b0);

      // Reset during the 2nd ADD cycle discards the partial result.
      @(negedge clk);
      a = 16'h5555; b = 16'h5555; start = 1'b1;
      q.push_back(model(16'h5555, 16'h5555, 1'b1, 1'b0));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_sum", {16'd0, sum}, 32'd0);
      chk("midrst_carry", {31'd0, carry_out}, 32'd0);
      chk("midrst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_add(16'h5555, 16'h5555, 1'b1, 1'b0);

      // Single-digit instance.
      @(negedge clk);
      a1 = 4'h9; b1 = 4'h9; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("d1_busy", {31'd0, busy1}, 32'd1);
      lat1 = 0;
      while (!done1 && lat1 < 10) begin
         @(negedge clk);
         lat1++;
      end
      chk("d1_latency", lat1, 1);
      chk("d1_sum", {28'd0, sum1}, 32'h8);
      chk("d1_carry", {31'd0, carry1}, 32'd1);
      chk("d1_err", {31'd0, err1}, 32'd0);

`ifdef BCD_SEQ_INVALID_CHECK_EN
      do_add(16'h00A0, 16'h0000, 1'b0, 1'b1);
      chk("err_held", {31'd0, err}, 32'd1);
      do_add(16'h0001, 16'h0001, 1'b1, 1'b0);
`else
      do_add(16'h00A0, 16'h0000, 1'b0, 1'b0);
      do_add(16'h0001, 16'h0001, 1'b1, 1'b0);
`endif

      repeat (3) @(negedge clk);
      chk("sb_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
